// File: rtl/mole_pkg.sv
// Shared types and constants for the whack-a-mole engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package mole_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SHOW = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'h01;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;   // taps 8,6,5,4
    localparam logic [2:0] LEVEL_MAX = 3'd7;

    // Durations of zero would stall a countdown; treat them as one cycle.
    function automatic logic [31:0] clamp_min1(input logic [31:0] value);
        return (value == 32'd0) ? 32'd1 : value;
    endfunction

endpackage

// File: rtl/mole_lfsr.sv
// Free-running 8-bit Fibonacci LFSR used to pick the next mole.
// Latency: new value every cycle, registered output.
// Backpressure: none; advances unconditionally in every state.
module mole_lfsr
    import mole_pkg::*;
(
    input  logic       clock,
    input  logic       resetn,
    output logic [7:0] lfsr_o
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    // Shift left, feeding back the XOR of the tapped bits; seed is non-zero so 0 is never reached.
    always_comb begin
        lfsr_d = {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // State register with synchronous active-low reset to the seed.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/mole_game_core.sv
// Whack-a-mole engine: mole pick, display/gap timers, scoring, misses, level speed-up.
// Latency: a button sampled at edge k affects hit/score/moles/state after edge k+1.
// Backpressure: none; buttons are sampled every cycle and all outputs are registered.
module mole_game_core
    import mole_pkg::*;
#(
    parameter int NUM_MOLES  = 3,
    parameter int SCORE_W    = 8,
    parameter int TIMER_W    = 28,
    parameter int MAX_MISSES = 3,
    parameter int LEVEL_HITS = 8
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic                 game,
    input  logic [NUM_MOLES-1:0] buttons,
    input  logic [TIMER_W-1:0]   speed,
    input  logic [TIMER_W-1:0]   gap,
    output logic [NUM_MOLES-1:0] moles,
    output logic [SCORE_W-1:0]   score,
    output logic [3:0]           misses,
    output logic [2:0]           level,
    output logic                 hit,
    output logic                 game_over
);

    localparam int IDX_W = $clog2(NUM_MOLES);
    localparam int HIT_W = (LEVEL_HITS > 1) ? $clog2(LEVEL_HITS) : 1;

    state_t               state_q, state_d;
    logic [TIMER_W-1:0]   timer_q, timer_d;
    logic [NUM_MOLES-1:0] moles_q, moles_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic [3:0]           misses_q, misses_d;
    logic [2:0]           level_q, level_d;
    logic [HIT_W-1:0]     hits_q, hits_d;
    logic                 hit_q, hit_d;
    logic                 game_over_q, game_over_d;
    logic [NUM_MOLES-1:0] btn_q, prev_q;

    logic [7:0]           lfsr;
    logic [IDX_W-1:0]     rnd, mole_idx;
    logic [NUM_MOLES-1:0] pick_mask, edges;
    logic                 lit_edge, wrong_edge;
    logic [31:0]          gap_len, show_len;
    logic [TIMER_W-1:0]   gap_load, show_load;

    mole_lfsr u_lfsr (
        .clock  (clock),
        .resetn (resetn),
        .lfsr_o (lfsr)
    );

    // Derived values: timer reloads, folded mole index, and button rising edges.
    always_comb begin
        gap_len    = clamp_min1(32'(gap));
        show_len   = clamp_min1(clamp_min1(32'(speed)) >> level_q);
        gap_load   = TIMER_W'(gap_len - 32'd1);
        show_load  = TIMER_W'(show_len - 32'd1);
        rnd        = lfsr[IDX_W-1:0];
        mole_idx   = (32'(rnd) < NUM_MOLES) ? rnd : rnd - IDX_W'(NUM_MOLES);
        pick_mask  = NUM_MOLES'(1) << mole_idx;
        edges      = btn_q & ~prev_q;
        lit_edge   = |(edges & moles_q);
        wrong_edge = |(edges & ~moles_q);
    end

    // Next-state and output logic; a hit on the lit mole outranks any wrong press or timeout.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        moles_d     = moles_q;
        score_d     = score_q;
        misses_d    = misses_q;
        level_d     = level_q;
        hits_d      = hits_q;
        hit_d       = 1'b0;
        game_over_d = game_over_q;
        if (!game) begin
            state_d     = ST_IDLE;
            moles_d     = '0;
            game_over_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    score_d     = '0;
                    misses_d    = '0;
                    level_d     = '0;
                    hits_d      = '0;
                    moles_d     = '0;
                    game_over_d = 1'b0;
                    timer_d     = gap_load;
                    state_d     = ST_GAP;
                end
                ST_GAP: begin
                    if (timer_q == '0) begin
                        state_d = ST_SHOW;
                        timer_d = show_load;
                        moles_d = pick_mask;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (lit_edge) begin
                        hit_d   = 1'b1;
                        moles_d = '0;
                        state_d = ST_GAP;
                        timer_d = gap_load;
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                        if (hits_q == HIT_W'(LEVEL_HITS - 1)) begin
                            hits_d = '0;
                            if (level_q != LEVEL_MAX) begin
                                level_d = level_q + 3'd1;
                            end
                        end else begin
                            hits_d = hits_q + HIT_W'(1);
                        end
                    end else begin
                        if (wrong_edge && score_q != '0) begin
                            score_d = score_q - SCORE_W'(1);
                        end
                        if (timer_q == '0) begin
                            misses_d = misses_q + 4'd1;
                            moles_d  = '0;
                            if (misses_q + 4'd1 == 4'(MAX_MISSES)) begin
                                state_d     = ST_OVER;
                                game_over_d = 1'b1;
                            end else begin
                                state_d = ST_GAP;
                                timer_d = gap_load;
                            end
                        end else begin
                            timer_d = timer_q - TIMER_W'(1);
                        end
                    end
                end
                ST_OVER: begin
                    moles_d     = '0;
                    game_over_d = 1'b1;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State, counters and button history with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            moles_q     <= '0;
            score_q     <= '0;
            misses_q    <= '0;
            level_q     <= '0;
            hits_q      <= '0;
            hit_q       <= 1'b0;
            game_over_q <= 1'b0;
            btn_q       <= '0;
            prev_q      <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            moles_q     <= moles_d;
            score_q     <= score_d;
            misses_q    <= misses_d;
            level_q     <= level_d;
            hits_q      <= hits_d;
            hit_q       <= hit_d;
            game_over_q <= game_over_d;
            btn_q       <= buttons;
            prev_q      <= btn_q;
        end
    end

    assign moles     = moles_q;
    assign score     = score_q;
    assign misses    = misses_q;
    assign level     = level_q;
    assign hit       = hit_q;
    assign game_over = game_over_q;

endmodule

// File: tb/tb_mole_game_core.sv
module tb_mole_game_core;
    import mole_pkg::*;

    logic        clock, resetn, game;
    logic [4:0]  buttons, moles;
    logic [27:0] speed, gap;
    logic [3:0]  score, misses;
    logic [2:0]  level;
    logic        hit, game_over;

    int checks = 0;
    int errors = 0;
    int exp_score_q[$];
    int exp_level_q[$];
    int exp_miss_q[$];
    int m_score, m_level, m_hits;

    mole_game_core #(
        .NUM_MOLES(5), .SCORE_W(4), .TIMER_W(28), .MAX_MISSES(3), .LEVEL_HITS(2)
    ) dut (
        .clock(clock), .resetn(resetn), .game(game), .buttons(buttons),
        .speed(speed), .gap(gap), .moles(moles), .score(score),
        .misses(misses), .level(level), .hit(hit), .game_over(game_over)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_lit(output int idx);
        int n = 0;
        idx = 0;
        while (moles == 5'b0 && n < 200) begin
            tick();
            n++;
        end
        if (moles == 5'b0) begin
            checks++; errors++;
            $display("FAIL wait_lit: moles=%b after %0d cycles, required a lit mole", moles, n);
        end else begin
            for (int i = 4; i >= 0; i--) if (moles[i]) idx = i;
        end
    endtask

    task automatic model_reset;
        m_score = 0; m_level = 0; m_hits = 0;
        exp_score_q.delete(); exp_level_q.delete(); exp_miss_q.delete();
    endtask

    task automatic restart;
        game = 1'b0; buttons = '0;
        tick();
        game = 1'b1;
        tick();
        model_reset();
    endtask

    // Drive one press for one cycle; push the expected score/level it should produce.
    task automatic press(input logic [4:0] pat, input bit correct);
        if (correct) begin
            m_score = (m_score == 15) ? 15 : m_score + 1;
            m_hits++;
            if (m_hits == 2) begin
                m_hits = 0;
                if (m_level < 7) m_level++;
            end
        end else begin
            m_score = (m_score == 0) ? 0 : m_score - 1;
        end
        exp_score_q.push_back(m_score);
        exp_level_q.push_back(m_level);
        buttons = pat;
        tick();
        buttons = '0;
        tick();
    endtask

    task automatic test_reset;
        int n;
        resetn = 1'b0; game = 1'b1; buttons = '0; speed = 28'd5; gap = 28'd2;
        model_reset();
        repeat (3) tick();
        checks++;
        if ({moles, score, misses, level, hit, game_over} !== 18'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b, required all zero", {moles, score, misses, level, hit, game_over});
        end
        checks++;
        if (dut.state_q !== ST_IDLE) begin
            errors++; $display("FAIL reset_state: got %0d, required IDLE", dut.state_q);
        end
        resetn = 1'b1;
        tick();
        checks++;
        if (dut.state_q !== ST_GAP) begin
            errors++; $display("FAIL reset_to_gap: got %0d, required GAP", dut.state_q);
        end
        n = 0;
        while (moles == 5'b0 && n < 50) begin
            n++;
            tick();
        end
        checks++;
        if (n != 2 || !$onehot(moles)) begin
            errors++; $display("FAIL first_mole: gap %0d moles %b, required gap 2 one-hot", n, moles);
        end
    endtask

    task automatic test_timeouts;
        int idx, len, g, em;
        for (int k = 1; k <= 3; k++) begin
            wait_lit(idx);
            exp_miss_q.push_back(k);
            len = 0;
            while (moles != 5'b0 && len < 50) begin
                len++;
                tick();
            end
            checks++;
            if (len != 5) begin
                errors++; $display("FAIL show_len_timeout: got %0d cycles, required 5", len);
            end
            em = exp_miss_q.pop_front();
            checks++;
            if (misses !== 4'(em)) begin
                errors++; $display("FAIL misses: got %0d, required %0d", misses, em);
            end
            checks++;
            if (game_over !== (k == 3)) begin
                errors++; $display("FAIL game_over_edge: got %b, required %b", game_over, (k == 3));
            end
            if (k < 3) begin
                g = 0;
                while (moles == 5'b0 && g < 50) begin
                    g++;
                    tick();
                end
                checks++;
                if (g != 2) begin
                    errors++; $display("FAIL gap_len: got %0d cycles, required 2", g);
                end
            end
        end
        repeat (4) tick();
        checks++;
        if (game_over !== 1'b1 || moles !== 5'b0 || dut.state_q !== ST_OVER) begin
            errors++; $display("FAIL over_hold: go=%b moles=%b st=%0d, required 1/0/OVER", game_over, moles, dut.state_q);
        end
        game = 1'b0;
        tick();
        checks++;
        if (game_over !== 1'b0 || dut.state_q !== ST_IDLE || misses !== 4'd3) begin
            errors++; $display("FAIL over_exit: go=%b st=%0d misses=%0d, required 0/IDLE/3", game_over, dut.state_q, misses);
        end
    endtask

    task automatic test_hit;
        int idx, es, el;
        speed = 28'd5; gap = 28'd2;
        restart();
        wait_lit(idx);
        tick();
        press(5'b00001 << idx, 1'b1);
        es = exp_score_q.pop_front(); el = exp_level_q.pop_front();
        checks++;
        if (hit !== 1'b1 || score !== 4'(es) || moles !== 5'b0 || dut.state_q !== ST_GAP) begin
            errors++;
            $display("FAIL hit_response: hit=%b score=%0d moles=%b st=%0d, required 1/%0d/0/GAP", hit, score, moles, dut.state_q, es);
        end
        checks++;
        if (level !== 3'(el)) begin
            errors++; $display("FAIL hit_level: got %0d, required %0d", level, el);
        end
        tick();
        checks++;
        if (hit !== 1'b0) begin
            errors++; $display("FAIL hit_pulse_width: got %b, required 0", hit);
        end
    endtask

    task automatic test_wrong;
        int idx, w, es, el;
        logic [4:0] pat [5];
        bit         cor [5];
        bit         new_mole [5];
        speed = 28'd20; gap = 28'd2;
        restart();
        // step table: wrong@0, right, right, wrong@2, right+wrong
        for (int s = 0; s < 5; s++) begin
            new_mole[s] = (s == 0 || s == 2 || s == 3);
        end
        cor = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        idx = 0;
        for (int s = 0; s < 5; s++) begin
            if (new_mole[s]) wait_lit(idx);
            w = (idx + 1) % 5;
            pat[s] = (s == 4) ? ((5'b00001 << idx) | (5'b00001 << w)) :
                     cor[s]   ? (5'b00001 << idx) : (5'b00001 << w);
            press(pat[s], cor[s]);
            es = exp_score_q.pop_front(); el = exp_level_q.pop_front();
            checks++;
            if (score !== 4'(es) || hit !== cor[s] || level !== 3'(el)) begin
                errors++;
                $display("FAIL wrong_step%0d: score=%0d hit=%b level=%0d, required %0d/%b/%0d", s, score, hit, level, es, cor[s], el);
            end
            if (!cor[s]) begin
                checks++;
                if (moles !== (5'b00001 << idx)) begin
                    errors++; $display("FAIL wrong_keeps_mole: got %b, required %b", moles, 5'b00001 << idx);
                end
            end
        end
    endtask

    task automatic test_level;
        int idx, len, es, el;
        speed = 28'd16; gap = 28'd2;
        restart();
        for (int h = 0; h < 16; h++) begin
            if (h == 4) begin
                checks++;
                if (level !== 3'd2) begin
                    errors++; $display("FAIL level_after4: got %0d, required 2", level);
                end
                wait_lit(idx);
                len = 0;
                while (moles != 5'b0 && len < 50) begin
                    len++;
                    tick();
                end
                checks++;
                if (len != 4 || misses !== 4'd1) begin
                    errors++; $display("FAIL level2_show: len=%0d misses=%0d, required 4/1", len, misses);
                end
                speed = 28'd1000;
            end
            wait_lit(idx);
            press(5'b00001 << idx, 1'b1);
            es = exp_score_q.pop_front(); el = exp_level_q.pop_front();
            checks++;
            if (score !== 4'(es) || level !== 3'(el)) begin
                errors++; $display("FAIL level_hit%0d: score=%0d level=%0d, required %0d/%0d", h, score, level, es, el);
            end
        end
        checks++;
        if (level !== 3'd7) begin
            errors++; $display("FAIL level_cap: got %0d, required 7", level);
        end
        speed = 28'd1;
        wait_lit(idx);
        len = 0;
        while (moles != 5'b0 && len < 50) begin
            len++;
            tick();
        end
        checks++;
        if (len != 1 || misses !== 4'd2) begin
            errors++; $display("FAIL level7_speed1: len=%0d misses=%0d, required 1/2", len, misses);
        end
    endtask

    task automatic test_saturate;
        int idx, es;
        speed = 28'd1000; gap = 28'd1;
        restart();
        for (int h = 0; h < 20; h++) begin
            wait_lit(idx);
            press(5'b00001 << idx, 1'b1);
            es = exp_score_q.pop_front();
            void'(exp_level_q.pop_front());
            checks++;
            if (score !== 4'(es)) begin
                errors++; $display("FAIL saturate_hit%0d: got %0d, required %0d", h, score, es);
            end
        end
        checks++;
        if (score !== 4'd15) begin
            errors++; $display("FAIL saturate_final: got %0d, required 15", score);
        end
    endtask

    task automatic test_back_to_back;
        int idx, es, bad;
        bit seen [5];
        speed = 28'd1000; gap = 28'd1;
        restart();
        bad = 0;
        for (int i = 0; i < 5; i++) seen[i] = 1'b0;
        for (int m = 0; m < 1000; m++) begin
            wait_lit(idx);
            if (!$onehot(moles)) bad++;
            seen[idx] = 1'b1;
            press(5'b00001 << idx, 1'b1);
            es = exp_score_q.pop_front();
            void'(exp_level_q.pop_front());
            checks++;
            if (score !== 4'(es) || hit !== 1'b1) begin
                errors++; $display("FAIL b2b_hit%0d: score=%0d hit=%b, required %0d/1", m, score, hit, es);
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL onehot: %0d non-one-hot moles, required 0", bad);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (!seen[i]) begin
                errors++; $display("FAIL coverage_idx%0d: never lit, required at least once", i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_timeouts();
        test_hit();
        test_wrong();
        test_level();
        test_saturate();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mole_game_core.md
# mole_game_core

Parametrised whack-a-mole game engine: N moles, free-running LFSR mole selection, per-mole display timer, button edge detection, score, miss budget and automatic level speed-up. It replaces the fixed three-mole player/display pair and sits between the board buttons/switches and the score display decoders. One synchronous FSM owns every counter, and every output is registered.

## Interface
- NUM_MOLES, 3: number of moles/buttons, 2..16; IDX_W = clog2(NUM_MOLES).
- SCORE_W, 8: score width; score saturates at 2^SCORE_W-1.
- TIMER_W, 28: width of the speed/gap inputs and of the internal timer.
- MAX_MISSES, 3: number of timeouts that ends the game, 1..15.
- LEVEL_HITS, 8: hits per level step.
- clock  in  1  system clock; every flop is rising-edge.
- resetn  in  1  synchronous active-low reset.
- game  in  1  level; 1 = play, 0 = stop and return to IDLE.
- buttons  in  NUM_MOLES  raw button levels, already synchronised, active-high.
- speed  in  TIMER_W  base mole display time in cycles; 0 is treated as 1.
- gap  in  TIMER_W  blank time between moles in cycles; 0 is treated as 1.
- moles  out  NUM_MOLES  one-hot lit mole, all zero outside SHOW.
- score  out  SCORE_W  current score.
- misses  out  4  timeouts so far.
- level  out  3  current level, 0..7.
- hit  out  1  one-cycle pulse on a correct whack.
- game_over  out  1  high in OVER.

## Operation
- States: IDLE, GAP, SHOW, OVER.
- Reset: state IDLE; moles 0, score 0, misses 0, level 0, hit 0, game_over 0; LFSR = 8'h01; button history = 0.
- LFSR: 8-bit Fibonacci, XOR feedback, taps 8,6,5,4. It advances every cycle in every state, so it never sits at 0.
- Mole pick on GAP->SHOW: r = LFSR[IDX_W-1:0]; idx = r if r < NUM_MOLES, else r - NUM_MOLES.
- Button edges: edge[i] = buttons[i] & ~prev[i]; prev updates every cycle. Edges are acted on only in SHOW.
- IDLE: on game=1, clear score/misses/level and go to GAP.
- GAP: the timer counts down from max(gap,1)-1; at 0, go to SHOW.
- SHOW timer:
  - Display length show_len = max(max(speed,1) >> level, 1).
  - On entry, load show_len-1 and light moles[idx].
- SHOW events, in priority order:
  - Edge on the lit mole: hit pulse; score+1 (saturating); go to GAP.
  - Wrong-button edge only: score-1, floored at 0; the mole stays lit; the timer keeps running.
  - A correct and a wrong edge in the same cycle: counts as a hit only, with no penalty.
  - Timer reaches 0 with no hit: misses+1. If misses equals MAX_MISSES, go to OVER; otherwise go to GAP.
- Level: kept as a hit counter mod LEVEL_HITS. When it wraps, level+1, saturating at 7. The new level applies from the next SHOW.
- OVER: moles 0, game_over 1, score and misses held. Leaves only when game=0 (to IDLE).
- game=0 in any state goes to IDLE next cycle: moles 0, score held for display. Cleared only on the next IDLE->GAP.
- resetn=0 overrides everything, mid-SHOW included, and returns to the reset state on the next edge.

## Timing
- All outputs are registered. A button edge sampled at edge k:
  - hit, score, moles=0 and the state change are visible after edge k+1.
- Mole lit for exactly show_len cycles if not hit. Blank for exactly max(gap,1) cycles between moles.
- Held button: one edge only. It must be released and re-pressed to count again.
- game_over asserts on the same edge that clears moles for the final miss.

## Structure
- Package mole_pkg:
  - State enum.
  - LFSR seed 8'h01 and tap mask 8'hB8.
  - Level cap 7.
  - Function clamp_min1(value).
- Sub-module mole_lfsr: clock, resetn, 8-bit out, free-running. Everything else stays in mole_game_core.
- The seven-segment decoders stay outside this block.

## Test plan
- Reset with game=1 held -> all outputs 0, state IDLE until resetn rises; then GAP; the first mole lights after gap cycles.
- speed=5, gap=2, no presses, MAX_MISSES=3:
  - Each mole is lit 5 cycles and misses goes 1,2,3.
  - game_over=1 and moles=0 after the third timeout; game_over is held until game=0.
- Press the lit button on the 2nd SHOW cycle -> hit pulses for 1 cycle, score 0->1, moles clear the next cycle, GAP follows.
- Wrong button at score=0 -> score stays 0. Wrong button at score=2 -> score 1, mole still lit. Correct and wrong buttons in the same cycle -> score+1 only.
- LEVEL_HITS=2, speed=16: four hits -> level 2, next mole lit 4 cycles. Speed=1 at level 7 -> lit 1 cycle.
- NUM_MOLES=5 over 1000 moles -> every index 0..4 appears, moles always one-hot. SCORE_W=4 with 20 hits -> score holds at 15.
